axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits (2^ADDR_W x 32-bit words).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte base address of the window (aligned to 2^(ADDR_W+2)).
REQ-003 SHALL have port aclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port areset  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports awaddr in 32, awlen in 8, awsize in 3, awvalid in 1, awready out 1: write-address channel.
REQ-006 SHALL have ports wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1: write-data channel.
REQ-007 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write-response channel.
REQ-008 SHALL have ports araddr in 32, arlen in 8, arsize in 3, arvalid in 1, arready out 1: read-address channel.
REQ-009 SHALL have ports rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1: read-data channel.

Function
REQ-010 SHALL be the downstream AXI slave of the CPU cache/bridge master; single-beat transfers only; one outstanding read and one outstanding write; the read and write paths run independently.
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-012 W_IDLE->W_DATA on awvalid&&awready; the FSM SHALL latch awaddr and awlen on that edge.
REQ-013 W_DATA->W_RESP on wvalid&&wready; on that edge the FSM SHALL write byte lane i of word awaddr[ADDR_W+1:2] only where wstrb[i]=1 and the response is OKAY.
REQ-014 W_RESP->W_IDLE on bvalid&&bready; bresp SHALL stay stable while bvalid=1.
REQ-015 Read FSM SHALL have states R_IDLE, R_ACCESS, R_DATA; arready=1 only in R_IDLE; rvalid=1 only in R_DATA.
REQ-016 R_IDLE->R_ACCESS on arvalid&&arready, latching araddr and arlen; R_ACCESS->R_DATA unconditionally, at the edge where array data are registered into rdata; rvalid SHALL therefore rise 2 cycles after the AR handshake edge.
REQ-017 R_DATA->R_IDLE on rvalid&&rready; rdata, rresp and rlast SHALL stay stable while rvalid=1; rlast SHALL be 1 whenever rvalid=1.
REQ-018 Response codes SHALL be: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-019 An address whose bits [31:ADDR_W+2] differ from BASE SHALL give DECERR; any such write SHALL be suppressed, and any such read SHALL return rdata=0.
REQ-020 awlen!=0 or arlen!=0 SHALL give SLVERR and the FSM SHALL accept exactly one beat; the write is suppressed and rdata=0; DECERR takes priority over SLVERR.
REQ-021 awsize, arsize, wlast and address bits [1:0] SHALL be ignored (word-aligned access; byte selection via wstrb only).
REQ-022 A read in R_ACCESS and a write commit to the same word in the same cycle SHALL return the pre-write (old) data.
REQ-023 The AR and AW handshakes SHALL be accepted in the same cycle when both FSMs are idle; there is no arbitration between the paths.

Reset
REQ-024 On areset=1 at a clock edge both FSMs SHALL go to the IDLE state; outputs SHALL reset to awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0, rlast=0.
REQ-025 awready and arready SHALL assert the first cycle after areset deasserts.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no response, and an unfinished write SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be reset.

Structure
REQ-028 The response codes (OKAY/SLVERR/DECERR) and the FSM state encodings SHALL live in the shared package axi_pkg.
REQ-029 Storage SHALL be one sub-module sram_2p: one write port with 4-bit byte enable and one registered read port, read-first, one-cycle read latency.

Verification
REQ-030 Write then read, with the bench: AW 0x10, W 0xDEADBEEF with wstrb 4'hF, then AR 0x10 -> bresp=00, rdata=0xDEADBEEF, rresp=00, rlast=1, rvalid asserted 2 cycles after the AR handshake.
REQ-031 Byte strobe, with the bench: preload 0x11223344, write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
REQ-032 Errors, with the bench: AW 0x0001_0000 (outside window) -> bresp=11 and no array change; AR with arlen=3 -> single beat, rresp=10, rdata=0, rlast=1.
REQ-033 Backpressure, with the bench: hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid and their payloads stay stable, awready=0 and arready=0 throughout.
REQ-034 Collision and reset, with the bench: read and write commit to word 0x20 in the same cycle -> old data returned; areset pulsed while in W_DATA -> no response issued, word unchanged, awready=1 one cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response codes, FSM state encodings and address-window decode.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCESS,
        R_DATA
    } r_state_t;

    // Response for a single-beat request: window miss beats a burst request.
    function automatic logic [1:0] decode_resp(input logic [31:0]   addr,
                                               input logic [31:0]   base,
                                               input int unsigned   addr_w,
                                               input logic [7:0]    len);
        logic [31:0] w_mask;
        w_mask = 32'hFFFF_FFFF << (addr_w + 2);
        if ((addr & w_mask) != (base & w_mask)) begin
            return RESP_DECERR;
        end
        if (len != 8'd0) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_2p.sv
// Two-port SRAM: byte-enabled write port, registered read-first read port.
module sram_2p #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wbe,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // Array and read register are not reset; a same-cycle write is seen only by later reads.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wbe[i]) begin
                    r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a 2^ADDR_W x 32-bit SRAM; independent read/write FSMs.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    w_state_t          r_wstate;
    w_state_t          w_wstate_next;
    logic [ADDR_W-1:0] r_waddr;
    logic [1:0]        r_bresp;
    logic              w_we;

    r_state_t          r_rstate;
    r_state_t          w_rstate_next;
    logic [ADDR_W-1:0] r_raddr;
    logic [1:0]        r_rresp;
    logic              w_re;
    logic [31:0]       w_sram_rdata;

    // Size and last are irrelevant for word-wide single beats.
    logic              w_unused;
    assign w_unused = ^{awsize, arsize, wlast};

    // Write state register; address and response captured at the AW handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_next;
            if (awvalid && awready) begin
                r_waddr <= awaddr[ADDR_W+1:2];
                r_bresp <= decode_resp(awaddr, BASE, ADDR_W, awlen);
            end
        end
    end

    // Write next-state and handshake outputs; everything held low while in reset.
    always_comb begin
        w_wstate_next = r_wstate;
        awready       = 1'b0;
        wready        = 1'b0;
        bvalid        = 1'b0;
        if (!areset) begin
            unique case (r_wstate)
                W_IDLE: begin
                    awready = 1'b1;
                    if (awvalid) w_wstate_next = W_DATA;
                end
                W_DATA: begin
                    wready = 1'b1;
                    if (wvalid) w_wstate_next = W_RESP;
                end
                W_RESP: begin
                    bvalid = 1'b1;
                    if (bready) w_wstate_next = W_IDLE;
                end
                default: w_wstate_next = W_IDLE;
            endcase
        end
    end

    assign w_we  = wvalid && wready && (r_bresp == RESP_OKAY);
    assign bresp = bvalid ? r_bresp : RESP_OKAY;

    // Read state register; address and response captured at the AR handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if (arvalid && arready) begin
                r_raddr <= araddr[ADDR_W+1:2];
                r_rresp <= decode_resp(araddr, BASE, ADDR_W, arlen);
            end
        end
    end

    // Read next-state and handshake outputs; R_ACCESS is the array read cycle.
    always_comb begin
        w_rstate_next = r_rstate;
        arready       = 1'b0;
        rvalid        = 1'b0;
        if (!areset) begin
            unique case (r_rstate)
                R_IDLE: begin
                    arready = 1'b1;
                    if (arvalid) w_rstate_next = R_ACCESS;
                end
                R_ACCESS: begin
                    w_rstate_next = R_DATA;
                end
                R_DATA: begin
                    rvalid = 1'b1;
                    if (rready) w_rstate_next = R_IDLE;
                end
                default: w_rstate_next = R_IDLE;
            endcase
        end
    end

    assign w_re  = (r_rstate == R_ACCESS);
    // SRAM read register only loads in R_ACCESS, so rdata is stable through R_DATA.
    assign rdata = (rvalid && (r_rresp == RESP_OKAY)) ? w_sram_rdata : 32'h0;
    assign rresp = rvalid ? r_rresp : RESP_OKAY;
    assign rlast = rvalid;

    sram_2p #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .i_clk   (aclk),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (wdata),
        .i_wbe   (wstrb),
        .i_re    (w_re),
        .i_raddr (r_raddr),
        .o_rdata (w_sram_rdata)
    );

endmodule
